i2s_tx: RTL and testbench
=========================

I2S_TX -- requirements
Module: i2s_tx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 24: sample width in bits.
REQ-002 SHALL have parameter SLOT_WIDTH, default 32: sclk periods per channel slot; SLOT_WIDTH >= DATA_WIDTH+1.
REQ-003 SHALL have ports (clock and reset first):
  clk  input  1  system clock, 100 MHz; the only clock in the block.
  reset_n  input  1  asynchronous, active-low reset.
  en  input  1  serializer enable.
  sclk_fall_tick  input  1  one-clk pulse per tx_sclk falling edge, from the clock generator.
  s_valid  input  1  sample pair valid.
  s_ready  output  1  holding register can accept a pair.
  s_left  input  DATA_WIDTH  left sample, two's complement.
  s_right  input  DATA_WIDTH  right sample, two's complement.
  tx_lrck  output  1  word select: 0 = left, 1 = right.
  tx_sdata  output  1  serial data, I2S format.
  underrun  output  1  one-clk pulse when a frame loads with no sample held.

Function
REQ-004 SHALL keep bit_cnt, 0..2*SLOT_WIDTH-1, advanced by one modulo 2*SLOT_WIDTH only on clk edges where en && sclk_fall_tick.
REQ-005 SHALL register tx_lrck = (new bit_cnt >= SLOT_WIDTH) in the same clk as the bit_cnt update. Outputs change exactly 1 clk after the tick.
REQ-006 SHALL keep a 2*SLOT_WIDTH-bit frame register. Left is MSB-justified at [2S-1:2S-DW], right at [S-1:S-DW], and all other bits are 0.
REQ-007 SHALL drive tx_sdata at bit_cnt k = frame[2S-1-((k-1) mod 2S)]. This is the I2S one-bit delay: the left MSB appears one sclk after tx_lrck falls.
REQ-008 SHALL load the frame on the tick where bit_cnt goes 0->1, using the holding register if it is full and all zeros otherwise. An empty load pulses underrun.
REQ-009 SHALL set s_ready = !hold_full and accept the pair when s_valid && s_ready.
REQ-010 SHALL clear hold_full on a frame load. s_ready rises the clk after the load.
REQ-011 SHALL give the load priority if an accept and a load fall in the same clk. Since hold_full=0, the load sees empty (underrun) and the accepted pair stays held for the next frame.
REQ-012 SHALL hold data stable: s_left/s_right changes while s_valid && !s_ready are ignored.
REQ-013 SHALL, when en=0, synchronously clear bit_cnt, frame, tx_lrck and tx_sdata to 0 while keeping the holding register contents. Re-enable starts the frame at bit_cnt 0.
REQ-014 SHALL ignore sclk_fall_tick while en=0.

Reset
REQ-015 SHALL, on reset_n=0, asynchronously set bit_cnt=0, frame=0, hold_full=0, tx_lrck=0, tx_sdata=0 and underrun=0. s_ready=1 after release.
REQ-016 SHALL, on reset mid-frame, restart from bit_cnt 0 and discard the held sample and the partial frame.

Configuration
REQ-017 SHALL, with macro I2S_TX_UNDERRUN_CNT_EN defined, add output underrun_cnt [15:0]. The counter increments on each underrun pulse, saturates at 16'hFFFF, and resets to 0 on reset_n only.
REQ-018 SHALL, without I2S_TX_UNDERRUN_CNT_EN, have neither the port nor the counter logic; the underrun pulse remains.

Structure
REQ-019 SHALL take I2S_DATA_WIDTH, I2S_SLOT_WIDTH and the sample-pair struct typedef (left, right) from shared package i2s_pkg. The clock generator and the top use the same package.
REQ-020 SHALL put the holding register plus valid/ready logic in sub-module i2s_tx_hold. bit_cnt, frame and the output logic stay in i2s_tx.

Verification
REQ-021 The bench SHALL cover:
- Reset: reset_n=0 mid-frame -> tx_lrck=0, tx_sdata=0, s_ready=1 within 0 clk (async).
- Pattern: left=24'hA5A5A5, right=24'h5A5A5A pushed before the first frame -> tx_sdata bits 1..24 after tx_lrck falls = A5A5A5 MSB-first, then 8 zeros. Bits 1..24 after tx_lrck rises = 5A5A5A.
- Underrun: no sample for 3 frames -> tx_sdata all 0, underrun pulses 3 times, underrun_cnt=3 (macro on).
- Backpressure: s_valid held high with incrementing data -> one pair accepted per frame, none lost or duplicated, s_ready low between loads.
- Collision: s_valid asserted in the exact clk of the 0->1 load with hold empty -> underrun pulses, and that pair appears in the following frame.
- Enable: en=0 for 100 clk mid-right-slot, then en=1 -> outputs 0 while disabled, held sample transmitted starting at bit_cnt 1 after re-enable.

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared I2S definitions: default widths and the sample-pair type used by
// the serializer and the sclk/lrck clock generator.
package i2s_pkg;

    localparam int I2S_DATA_WIDTH = 24;
    localparam int I2S_SLOT_WIDTH = 32;

    // One stereo sample pair; sized by I2S_DATA_WIDTH, so DATA_WIDTH of the
    // users must stay equal to it.
    typedef struct packed {
        logic [I2S_DATA_WIDTH-1:0] left;
        logic [I2S_DATA_WIDTH-1:0] right;
    } i2s_pair_t;

    // Bits per stereo frame (two slots).
    function automatic int i2s_frame_bits(input int slot_width);
        return 2 * slot_width;
    endfunction

endpackage

// File: rtl/i2s_tx_hold.sv
// Single-entry holding register for the I2S transmitter. Accepts one sample
// pair when empty; the frame loader empties it. An accept and a load in the
// same clk leave the new pair held (the load has already seen "empty").
module i2s_tx_hold
    import i2s_pkg::*;
#(
    parameter int DATA_WIDTH = I2S_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_left,
    input  logic [DATA_WIDTH-1:0] s_right,
    input  logic                  load,
    output logic                  hold_full,
    output i2s_pair_t             pair
);

    logic accept;

    assign s_ready = !hold_full;
    assign accept  = s_valid && !hold_full;

    // Capture on accept; a frame load empties the register unless a new pair
    // lands in the same clk.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_full <= 1'b0;
            pair      <= '0;
        end else if (accept) begin
            hold_full <= 1'b1;
            pair      <= '{left: s_left, right: s_right};
        end else if (load) begin
            hold_full <= 1'b0;
        end
    end

endmodule

// File: rtl/i2s_tx.sv
// I2S serializer. Advances one bit per sclk falling-edge tick, loads a new
// frame when bit_cnt goes 0->1 and emits data with the I2S one-bit delay.
// Optional feature: define I2S_TX_UNDERRUN_CNT_EN to add a saturating 16-bit
// underrun_cnt output.
module i2s_tx
    import i2s_pkg::*;
#(
    parameter int DATA_WIDTH = I2S_DATA_WIDTH,
    parameter int SLOT_WIDTH = I2S_SLOT_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  en,
    input  logic                  sclk_fall_tick,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_left,
    input  logic [DATA_WIDTH-1:0] s_right,
    output logic                  tx_lrck,
    output logic                  tx_sdata,
`ifdef I2S_TX_UNDERRUN_CNT_EN
    output logic [15:0]           underrun_cnt,
`endif
    output logic                  underrun
);

    localparam int FW = i2s_frame_bits(SLOT_WIDTH);
    localparam int CW = $clog2(FW);

    logic [CW-1:0] bit_cnt, cnt_nxt, sel;
    logic [FW-1:0] frame, frame_nxt, load_val;
    logic          tick, load, hold_full;
    i2s_pair_t     hold_pair;

    i2s_tx_hold #(.DATA_WIDTH(DATA_WIDTH)) u_hold (
        .clk       (clk),
        .reset_n   (reset_n),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_left    (s_left),
        .s_right   (s_right),
        .load      (load),
        .hold_full (hold_full),
        .pair      (hold_pair)
    );

    assign tick    = en && sclk_fall_tick;
    assign load    = tick && (bit_cnt == '0);
    assign cnt_nxt = (bit_cnt == CW'(FW - 1)) ? '0 : bit_cnt + CW'(1);

    // Bit shown at count k is frame[FW-1-((k-1) mod FW)]; k=0 shows bit 0.
    assign sel       = (cnt_nxt == '0) ? '0 : CW'(FW) - cnt_nxt;
    assign frame_nxt = load ? load_val : frame;

    // Build the MSB-justified frame from the holding register, or silence.
    always_comb begin
        load_val = '0;
        if (hold_full) begin
            load_val[FW-1 -: DATA_WIDTH]         = hold_pair.left;
            load_val[SLOT_WIDTH-1 -: DATA_WIDTH] = hold_pair.right;
        end
    end

    // Bit counter, frame and registered outputs; disable parks everything at 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt  <= '0;
            frame    <= '0;
            tx_lrck  <= 1'b0;
            tx_sdata <= 1'b0;
            underrun <= 1'b0;
        end else if (!en) begin
            bit_cnt  <= '0;
            frame    <= '0;
            tx_lrck  <= 1'b0;
            tx_sdata <= 1'b0;
            underrun <= 1'b0;
        end else begin
            underrun <= load && !hold_full;
            if (tick) begin
                bit_cnt  <= cnt_nxt;
                frame    <= frame_nxt;
                tx_lrck  <= (cnt_nxt >= CW'(SLOT_WIDTH));
                tx_sdata <= frame_nxt[sel];
            end
        end
    end

`ifdef I2S_TX_UNDERRUN_CNT_EN
    // Saturating count of underrun pulses; cleared only by reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            underrun_cnt <= '0;
        end else if (underrun && (underrun_cnt != 16'hFFFF)) begin
            underrun_cnt <= underrun_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_i2s_tx.sv
// Directed bench for i2s_tx: ticks every 4 clk, frames captured bit by bit.
module tb_i2s_tx;
    import i2s_pkg::*;

    localparam int DW = 24;
    localparam int SW = 32;
    localparam logic [63:0] LR_EXP = 64'h0000_0001_FFFF_FFFE;

    logic clk = 1'b0, reset_n = 1'b0, en = 1'b0, sclk_fall_tick = 1'b0, s_valid = 1'b0;
    logic [DW-1:0] s_left = '0, s_right = '0;
    logic s_ready, tx_lrck, tx_sdata, underrun;
`ifdef I2S_TX_UNDERRUN_CNT_EN
    logic [15:0] underrun_cnt;
`endif
    int n_checks = 0, n_pass = 0;

    i2s_tx #(.DATA_WIDTH(DW), .SLOT_WIDTH(SW)) dut (
        .clk(clk), .reset_n(reset_n), .en(en), .sclk_fall_tick(sclk_fall_tick),
        .s_valid(s_valid), .s_ready(s_ready), .s_left(s_left), .s_right(s_right),
        .tx_lrck(tx_lrck), .tx_sdata(tx_sdata),
`ifdef I2S_TX_UNDERRUN_CNT_EN
        .underrun_cnt(underrun_cnt),
`endif
        .underrun(underrun)
    );

    always #5 clk = ~clk;

    initial begin
        int div;
        div = 0;
        forever begin
            @(negedge clk);
            div = (div == 3) ? 0 : div + 1;
            sclk_fall_tick = (div == 3);
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog");
        $fatal(1);
    end

    function automatic logic [63:0] fr(input logic [23:0] l, input logic [23:0] r);
        return {l, 8'h00, r, 8'h00};
    endfunction

    task automatic wait_tick();
        int n;
        n = 0;
        do begin @(posedge clk); n++; end while (!(sclk_fall_tick && en) && n < 64);
        if (!(sclk_fall_tick && en)) begin n_checks++; $display("FAIL tick_timeout"); end
        #1;
    endtask

    // Capture ticks k=1..64 of a frame; bits comes out equal to the frame word.
    task automatic capture(output logic [63:0] bits, output logic ur, output logic rdy1,
                           output logic rdy32, output logic [63:0] lr);
        for (int k = 1; k <= 64; k++) begin
            wait_tick();
            bits[64-k] = tx_sdata;
            lr[64-k]   = tx_lrck;
            if (k == 1)  begin ur = underrun; rdy1 = s_ready; end
            if (k == 32) rdy32 = s_ready;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (tx_lrck !== 1'b0) $display("FAIL rst_lrck got=%b exp=0", tx_lrck); else n_pass++;
        n_checks++; if (tx_sdata !== 1'b0) $display("FAIL rst_sdata got=%b exp=0", tx_sdata); else n_pass++;
        n_checks++; if (s_ready !== 1'b1) $display("FAIL rst_ready got=%b exp=1", s_ready); else n_pass++;
        n_checks++; if (underrun !== 1'b0) $display("FAIL rst_underrun got=%b exp=0", underrun); else n_pass++;
        @(negedge clk); reset_n = 1'b1;
    endtask

    task automatic test_pattern();
        logic [63:0] b, lr; logic ur, r1, r32;
        @(negedge clk); s_valid = 1'b1; s_left = 24'hA5A5A5; s_right = 24'h5A5A5A;
        @(negedge clk); s_valid = 1'b0;
        n_checks++; if (s_ready !== 1'b0) $display("FAIL pat_held_ready got=%b exp=0", s_ready); else n_pass++;
        en = 1'b1;
        capture(b, ur, r1, r32, lr);
        n_checks++; if (b[63:40] !== 24'hA5A5A5) $display("FAIL pat_left got=%h exp=a5a5a5", b[63:40]); else n_pass++;
        n_checks++; if (b[39:32] !== 8'h00) $display("FAIL pat_lpad got=%h exp=00", b[39:32]); else n_pass++;
        n_checks++; if (b[31:8] !== 24'h5A5A5A) $display("FAIL pat_right got=%h exp=5a5a5a", b[31:8]); else n_pass++;
        n_checks++; if (b[7:0] !== 8'h00) $display("FAIL pat_rpad got=%h exp=00", b[7:0]); else n_pass++;
        n_checks++; if (lr !== LR_EXP) $display("FAIL pat_lrck got=%h exp=%h", lr, LR_EXP); else n_pass++;
        n_checks++; if (ur !== 1'b0) $display("FAIL pat_underrun got=%b exp=0", ur); else n_pass++;
        n_checks++; if (r1 !== 1'b1) $display("FAIL pat_ready_after_load got=%b exp=1", r1); else n_pass++;
    endtask

    task automatic test_underrun();
        logic [63:0] b, lr; logic ur, r1, r32;
        for (int f = 0; f < 3; f++) begin
            capture(b, ur, r1, r32, lr);
            n_checks++; if (b !== 64'h0) $display("FAIL ur_data%0d got=%h exp=0", f, b); else n_pass++;
            n_checks++; if (ur !== 1'b1) $display("FAIL ur_pulse%0d got=%b exp=1", f, ur); else n_pass++;
        end
`ifdef I2S_TX_UNDERRUN_CNT_EN
        n_checks++; if (underrun_cnt !== 16'd3) $display("FAIL ur_cnt got=%0d exp=3", underrun_cnt); else n_pass++;
`endif
    endtask

    task automatic test_back_to_back();
        logic [63:0] b[3], lr, bd; logic ur[3], r32[3], r1, urd, x;
        int acc; logic stop;
        acc = 0; stop = 1'b0;
        fork
            begin
                for (int f = 0; f < 3; f++) capture(b[f], ur[f], r1, r32[f], lr);
                stop = 1'b1;
            end
            begin
                while (!stop) begin
                    @(negedge clk);
                    if (stop) break;
                    s_valid = 1'b1;
                    s_left  = 24'hC00000 | 24'(acc);
                    s_right = 24'h300000 | 24'(acc);
                    if (s_ready) begin @(posedge clk); acc++; end
                end
                s_valid = 1'b0;
            end
        join
        for (int f = 0; f < 3; f++) begin
            n_checks++; if (b[f] !== fr(24'hC00000 | 24'(f), 24'h300000 | 24'(f)))
                $display("FAIL bp_data%0d got=%h exp=%h", f, b[f], fr(24'hC00000 | 24'(f), 24'h300000 | 24'(f)));
            else n_pass++;
            n_checks++; if (ur[f] !== 1'b0) $display("FAIL bp_underrun%0d got=%b exp=0", f, ur[f]); else n_pass++;
            n_checks++; if (r32[f] !== 1'b0) $display("FAIL bp_ready_mid%0d got=%b exp=0", f, r32[f]); else n_pass++;
        end
        n_checks++; if (acc !== 4) $display("FAIL bp_accepts got=%0d exp=4", acc); else n_pass++;
        capture(bd, urd, r1, x, lr);
        n_checks++; if (bd !== fr(24'hC00003, 24'h300003)) $display("FAIL bp_drain got=%h exp=%h", bd, fr(24'hC00003, 24'h300003)); else n_pass++;
        n_checks++; if (urd !== 1'b0) $display("FAIL bp_drain_underrun got=%b exp=0", urd); else n_pass++;
    endtask

    task automatic test_collision();
        logic [63:0] b0, b1, lr; logic ur0, ur1, r1a, r1b, x;
        fork
            begin
                capture(b0, ur0, r1a, x, lr);
                capture(b1, ur1, r1b, x, lr);
            end
            begin
                // Previous frame ended on a tick edge; the load tick is 4 clk later.
                repeat (4) @(negedge clk);
                s_valid = 1'b1; s_left = 24'h3C3C3C; s_right = 24'hC3C3C3;
                @(negedge clk); s_valid = 1'b0;
            end
        join
        n_checks++; if (b0 !== 64'h0) $display("FAIL col_first got=%h exp=0", b0); else n_pass++;
        n_checks++; if (ur0 !== 1'b1) $display("FAIL col_underrun got=%b exp=1", ur0); else n_pass++;
        n_checks++; if (r1a !== 1'b0) $display("FAIL col_held got=%b exp=0", r1a); else n_pass++;
        n_checks++; if (b1 !== fr(24'h3C3C3C, 24'hC3C3C3)) $display("FAIL col_next got=%h exp=%h", b1, fr(24'h3C3C3C, 24'hC3C3C3)); else n_pass++;
        n_checks++; if (ur1 !== 1'b0) $display("FAIL col_next_underrun got=%b exp=0", ur1); else n_pass++;
`ifdef I2S_TX_UNDERRUN_CNT_EN
        n_checks++; if (underrun_cnt !== 16'd4) $display("FAIL col_cnt got=%0d exp=4", underrun_cnt); else n_pass++;
`endif
    endtask

    task automatic test_enable();
        logic [63:0] b, lr; logic ur, r1, r32; int bad;
        wait_tick();
        n_checks++; if (underrun !== 1'b1) $display("FAIL en_pre_underrun got=%b exp=1", underrun); else n_pass++;
        @(negedge clk); s_valid = 1'b1; s_left = 24'h123456; s_right = 24'hFEDCBA;
        @(negedge clk); s_valid = 1'b0;
        repeat (39) wait_tick();
        n_checks++; if (tx_lrck !== 1'b1) $display("FAIL en_right_slot got=%b exp=1", tx_lrck); else n_pass++;
        @(negedge clk); en = 1'b0;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (tx_lrck !== 1'b0 || tx_sdata !== 1'b0) bad++;
        end
        n_checks++; if (bad != 0) $display("FAIL en_off_outputs got=%0d nonzero clk exp=0", bad); else n_pass++;
        n_checks++; if (s_ready !== 1'b0) $display("FAIL en_off_hold got=%b exp=0", s_ready); else n_pass++;
        @(negedge clk); en = 1'b1;
        capture(b, ur, r1, r32, lr);
        n_checks++; if (b !== fr(24'h123456, 24'hFEDCBA)) $display("FAIL en_resume got=%h exp=%h", b, fr(24'h123456, 24'hFEDCBA)); else n_pass++;
        n_checks++; if (ur !== 1'b0) $display("FAIL en_resume_underrun got=%b exp=0", ur); else n_pass++;
        n_checks++; if (lr !== LR_EXP) $display("FAIL en_resume_lrck got=%h exp=%h", lr, LR_EXP); else n_pass++;
`ifdef I2S_TX_UNDERRUN_CNT_EN
        n_checks++; if (underrun_cnt !== 16'd5) $display("FAIL en_cnt got=%0d exp=5", underrun_cnt); else n_pass++;
`endif
    endtask

    task automatic test_reset_midframe();
        logic [63:0] b, lr; logic ur, r1, r32;
        @(negedge clk); s_valid = 1'b1; s_left = 24'hFFFFFF; s_right = 24'hFFFFFF;
        @(negedge clk); s_valid = 1'b0;
        wait_tick();
        @(negedge clk); s_valid = 1'b1; s_left = 24'h777777; s_right = 24'h777777;
        @(negedge clk); s_valid = 1'b0;
        repeat (39) wait_tick();
        n_checks++; if (tx_sdata !== 1'b1) $display("FAIL rstm_pre_sdata got=%b exp=1", tx_sdata); else n_pass++;
        n_checks++; if (tx_lrck !== 1'b1) $display("FAIL rstm_pre_lrck got=%b exp=1", tx_lrck); else n_pass++;
        @(negedge clk); reset_n = 1'b0;
        #1;
        n_checks++; if (tx_lrck !== 1'b0) $display("FAIL rstm_lrck got=%b exp=0", tx_lrck); else n_pass++;
        n_checks++; if (tx_sdata !== 1'b0) $display("FAIL rstm_sdata got=%b exp=0", tx_sdata); else n_pass++;
        n_checks++; if (s_ready !== 1'b1) $display("FAIL rstm_ready got=%b exp=1", s_ready); else n_pass++;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        capture(b, ur, r1, r32, lr);
        n_checks++; if (b !== 64'h0) $display("FAIL rstm_discard got=%h exp=0", b); else n_pass++;
        n_checks++; if (ur !== 1'b1) $display("FAIL rstm_underrun got=%b exp=1", ur); else n_pass++;
`ifdef I2S_TX_UNDERRUN_CNT_EN
        n_checks++; if (underrun_cnt !== 16'd1) $display("FAIL rstm_cnt got=%0d exp=1", underrun_cnt); else n_pass++;
`endif
    endtask

    initial begin
        test_reset();
        test_pattern();
        test_underrun();
        test_back_to_back();
        test_collision();
        test_enable();
        test_reset_midframe();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
